// File: rtl/ysyx_220053_iter_mdu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220053_iter_mdu
// Brief    : Iterative radix-2 multiply/divide unit for the RV M extension
//            (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) with valid/ready on both
//            sides. Optional *W support is enabled by YSYX_220053_MDU_WORD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_220053_iter_mdu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_BUSY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state, w_state_next;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a, r_b, r_result;
    logic [CW-1:0]     r_cnt, w_last;
    logic              w_word, w_accept;
    logic              r_neg_res, r_neg_rem;
    logic [2*XLEN-1:0] r_acc, r_mcand;
    logic [XLEN-1:0]   r_mplier, r_rem, r_quo, r_dvs;

    assign w_accept = in_valid & ~flush & (r_state == S_IDLE);

`ifdef YSYX_220053_MDU_WORD_EN
    logic r_word;
    // Capture the *W qualifier with the request
    always_ff @(posedge clk) begin
        if (rst)           r_word <= 1'b0;
        else if (w_accept) r_word <= in_word;
    end
    assign w_word = r_word;
    assign w_last = r_word ? CW'(31) : CW'(XLEN-1);
`else
    logic w_unused_word;
    assign w_unused_word = in_word;
    assign w_word        = 1'b0;
    assign w_last        = CW'(XLEN-1);
`endif

    // Word results are the low 32 bits sign-extended to XLEN
    function automatic logic [XLEN-1:0] fit(input logic wd, input logic [XLEN-1:0] v);
`ifdef YSYX_220053_MDU_WORD_EN
        return wd ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
`else
        return wd ? v : v;
`endif
    endfunction

    // Operand decode: which operands are interpreted as signed
    logic w_is_div, w_sgn_a, w_sgn_b;
    assign w_is_div = r_op[2];
    assign w_sgn_a  = w_is_div ? ~r_op[0] : ((r_op[1:0] == 2'b01) || (r_op[1:0] == 2'b10));
    assign w_sgn_b  = w_is_div ? ~r_op[0] : (r_op[1:0] == 2'b01);

    // Operand extension (word ops narrow to 32 bits, sign/zero per op)
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_min, w_quo_init;
    always_comb begin
        w_a_ext = r_a;
        w_b_ext = r_b;
        w_min   = {1'b1, {(XLEN-1){1'b0}}};
`ifdef YSYX_220053_MDU_WORD_EN
        if (r_word) begin
            w_a_ext = {{(XLEN-32){w_sgn_a & r_a[31]}}, r_a[31:0]};
            w_b_ext = {{(XLEN-32){w_sgn_b & r_b[31]}}, r_b[31:0]};
            w_min   = {{(XLEN-31){1'b1}}, 31'b0};
        end
`endif
    end

    logic            w_a_neg, w_b_neg, w_div_zero, w_ovf, w_special;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_spec_raw;
    assign w_a_neg    = w_sgn_a & w_a_ext[XLEN-1];
    assign w_b_neg    = w_sgn_b & w_b_ext[XLEN-1];
    assign w_a_mag    = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag    = w_b_neg ? -w_b_ext : w_b_ext;
    assign w_div_zero = (w_b_ext == '0);
    assign w_ovf      = ~r_op[0] & (w_a_ext == w_min) & (&w_b_ext);
    assign w_special  = w_is_div & (w_div_zero | w_ovf);
    // Divide-by-zero takes priority; otherwise this is MIN / -1
    assign w_spec_raw = w_div_zero ? (r_op[1] ? w_a_ext : {XLEN{1'b1}})
                                   : (r_op[1] ? '0 : w_min);

    // Word dividends are left-aligned so 32 steps consume exactly their bits
    always_comb begin
        w_quo_init = w_a_mag;
`ifdef YSYX_220053_MDU_WORD_EN
        if (r_word) w_quo_init = w_a_mag << (XLEN-32);
`endif
    end

    // One shift-add and one restoring shift-subtract step, plus sign fix-up
    logic [2*XLEN-1:0] w_acc_step, w_prod;
    logic [XLEN:0]     w_rem_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_diff, w_rem_next, w_quo_next, w_quo_fix, w_rem_fix, w_norm_raw;
    always_comb begin
        w_acc_step  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_prod      = r_neg_res ? -w_acc_step : w_acc_step;
        w_rem_shift = {r_rem, r_quo[XLEN-1]};
        w_ge        = (w_rem_shift >= {1'b0, r_dvs});
        w_diff      = w_rem_shift[XLEN-1:0] - r_dvs;
        w_rem_next  = w_ge ? w_diff : w_rem_shift[XLEN-1:0];
        w_quo_next  = {r_quo[XLEN-2:0], w_ge};
        w_quo_fix   = r_neg_res ? -w_quo_next : w_quo_next;
        w_rem_fix   = r_neg_rem ? -w_rem_next : w_rem_next;
        if (w_is_div)
            w_norm_raw = r_op[1] ? w_rem_fix : w_quo_fix;
        else
            w_norm_raw = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic; flush returns any active state to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_PREP;
            S_PREP: if (flush) w_state_next = S_IDLE;
                    else if (w_special) w_state_next = S_DONE;
                    else w_state_next = S_BUSY;
            S_BUSY: if (flush) w_state_next = S_IDLE;
                    else if (r_cnt == w_last) w_state_next = S_DONE;
            S_DONE: if (flush | out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign out_result = r_result;

    // Datapath: latch request, prepare magnitudes, iterate, commit result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op <= in_op;
                    r_a  <= in_a;
                    r_b  <= in_b;
                end
                S_PREP: begin
                    r_cnt     <= '0;
                    r_acc     <= '0;
                    r_mcand   <= {{XLEN{1'b0}}, w_a_mag};
                    r_mplier  <= w_b_mag;
                    r_rem     <= '0;
                    r_quo     <= w_quo_init;
                    r_dvs     <= w_b_mag;
                    r_neg_res <= w_a_neg ^ w_b_neg;
                    r_neg_rem <= w_a_neg;
                    if (w_special) r_result <= fit(w_word, w_spec_raw);
                end
                S_BUSY: begin
                    r_cnt    <= r_cnt + CW'(1);
                    r_acc    <= w_acc_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_rem    <= w_rem_next;
                    r_quo    <= w_quo_next;
                    if (r_cnt == w_last) r_result <= fit(w_word, w_norm_raw);
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
